// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb: 2-read / 2-write register file with write-to-read bypass
// and a per-register pending-bit scoreboard for RAW stall detection.
module lc3_regfile_sb #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 3,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        ra1,
    input  logic [ADDR_W-1:0]        ra2,
    output logic [DATA_W-1:0]        rd1,
    output logic [DATA_W-1:0]        rd2,
    output logic                     rd1_busy,
    output logic                     rd2_busy,
    input  logic                     we_a,
    input  logic [ADDR_W-1:0]        wa_a,
    input  logic [DATA_W-1:0]        wd_a,
    input  logic                     we_b,
    input  logic [ADDR_W-1:0]        wa_b,
    input  logic [DATA_W-1:0]        wd_b,
    input  logic                     iss_v,
    input  logic [ADDR_W-1:0]        iss_dr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic [DEPTH-1:0]  w_hit_a;
    logic [DEPTH-1:0]  w_hit_b;
    logic [DEPTH-1:0]  w_iss;

    // Decode the write and issue addresses into one-hot per-register strobes
    always_comb begin
        w_hit_a = '0;
        w_hit_b = '0;
        w_iss   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit_a[i] = we_a  && (wa_a   == ADDR_W'(i));
            w_hit_b[i] = we_b  && (wa_b   == ADDR_W'(i));
            w_iss[i]   = iss_v && (iss_dr == ADDR_W'(i));
        end
    end

    // Register array: port B wins a same-address collision; r0 frozen when hardwired
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(ZERO_R0 && (i == 0))) begin
                    if (w_hit_b[i]) begin
                        r_mem[i] <= wd_b;
                    end else if (w_hit_a[i]) begin
                        r_mem[i] <= wd_a;
                    end
                end
            end
        end
    end

    // Scoreboard: issue sets, writeback clears, a same-cycle issue beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(ZERO_R0 && (i == 0))) begin
                    if (w_iss[i]) begin
                        r_pend[i] <= 1'b1;
                    end else if (w_hit_a[i] || w_hit_b[i]) begin
                        r_pend[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Read data for one port, applying bypass priority, hardwired r0 and reset masking
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = r_mem[ra];
        if (BYPASS) begin
            if (we_b && (wa_b == ra)) begin
                v = wd_b;
            end else if (we_a && (wa_a == ra)) begin
                v = wd_a;
            end
        end
        if (ZERO_R0 && (ra == '0)) begin
            v = '0;
        end
        if (!rst_n) begin
            v = '0;
        end
        return v;
    endfunction

    // Busy flag for one port; an in-flight writeback hides the pending bit unless re-issued
    function automatic logic f_busy(input logic [ADDR_W-1:0] ra);
        logic b;
        b = r_pend[ra];
        if (BYPASS && ((we_a && (wa_a == ra)) || (we_b && (wa_b == ra)))
                   && !(iss_v && (iss_dr == ra))) begin
            b = 1'b0;
        end
        if (!rst_n) begin
            b = 1'b0;
        end
        return b;
    endfunction

    // Combinational read ports
    always_comb begin
        rd1      = f_read(ra1);
        rd2      = f_read(ra2);
        rd1_busy = f_busy(ra1);
        rd2_busy = f_busy(ra2);
        busy_vec = r_pend;
    end

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Bench for lc3_regfile_sb: table-driven cycles with an expected-value queue,
// plus hand sequences for reset, no-bypass and hardwired-r0 builds.
module tb_lc3_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ra1, ra2, wa_a, wa_b, iss_dr;
    logic        we_a, we_b, iss_v;
    logic [15:0] wd_a, wd_b;

    logic [15:0] rd1, rd2, nb_rd1, nb_rd2, z_rd1, z_rd2;
    logic        rd1_busy, rd2_busy, nb_b1, nb_b2, z_b1, z_b2;
    logic [7:0]  busy_vec, nb_bv, z_bv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lc3_regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .iss_v(iss_v), .iss_dr(iss_dr),
        .busy_vec(busy_vec));

    lc3_regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
        .rd1_busy(nb_b1), .rd2_busy(nb_b2), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .iss_v(iss_v), .iss_dr(iss_dr),
        .busy_vec(nb_bv));

    lc3_regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(z_rd1), .rd2(z_rd2),
        .rd1_busy(z_b1), .rd2_busy(z_b2), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .iss_v(iss_v), .iss_dr(iss_dr),
        .busy_vec(z_bv));

    typedef struct {
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic [7:0]  e_bv;
    } exp_t;

    typedef struct {
        logic        p_we_a;
        logic [2:0]  p_wa_a;
        logic [15:0] p_wd_a;
        logic        p_we_b;
        logic [2:0]  p_wa_b;
        logic [15:0] p_wd_b;
        logic        p_iss;
        logic [2:0]  p_dr;
        logic [2:0]  p_ra1;
        logic [2:0]  p_ra2;
        exp_t        e;
    } row_t;

    localparam int NROWS = 19;
    row_t tbl [NROWS];
    exp_t exp_q [$];

    function automatic row_t mk(
        input logic a_we, input logic [2:0] a_wa, input logic [15:0] a_wd,
        input logic b_we, input logic [2:0] b_wa, input logic [15:0] b_wd,
        input logic i_v, input logic [2:0] i_dr,
        input logic [2:0] r1, input logic [2:0] r2,
        input logic [15:0] x1, input logic [15:0] x2,
        input logic y1, input logic y2, input logic [7:0] bv);
        row_t r;
        r.p_we_a = a_we; r.p_wa_a = a_wa; r.p_wd_a = a_wd;
        r.p_we_b = b_we; r.p_wa_b = b_wa; r.p_wd_b = b_wd;
        r.p_iss  = i_v;  r.p_dr   = i_dr;
        r.p_ra1  = r1;   r.p_ra2  = r2;
        r.e.e_rd1 = x1; r.e.e_rd2 = x2; r.e.e_b1 = y1; r.e.e_b2 = y2; r.e.e_bv = bv;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic idle();
        we_a = 1'b0; wa_a = 3'd0; wd_a = 16'h0;
        we_b = 1'b0; wa_b = 3'd0; wd_b = 16'h0;
        iss_v = 1'b0; iss_dr = 3'd0;
        ra1 = 3'd0; ra2 = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        //              we_a wa_a  wd_a      we_b wa_b  wd_b      iss  dr    ra1   ra2   rd1       rd2       b1    b2    busy_vec
        tbl[0]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd0,3'd7, 16'h0000,16'h0000,1'b0,1'b0,8'h00);
        tbl[1]  = mk(1'b1,3'd2,16'h1234, 1'b1,3'd5,16'hBEEF, 1'b0,3'd0, 3'd2,3'd5, 16'h1234,16'hBEEF,1'b0,1'b0,8'h00);
        tbl[2]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd2,3'd5, 16'h1234,16'hBEEF,1'b0,1'b0,8'h00);
        tbl[3]  = mk(1'b1,3'd3,16'h1111, 1'b1,3'd3,16'h2222, 1'b0,3'd0, 3'd3,3'd3, 16'h2222,16'h2222,1'b0,1'b0,8'h00);
        tbl[4]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd3,3'd2, 16'h2222,16'h1234,1'b0,1'b0,8'h00);
        tbl[5]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd4, 3'd4,3'd4, 16'h0000,16'h0000,1'b0,1'b0,8'h00);
        tbl[6]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd4,3'd3, 16'h0000,16'h2222,1'b1,1'b0,8'h10);
        tbl[7]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd4,3'd4, 16'h0000,16'h0000,1'b1,1'b1,8'h10);
        tbl[8]  = mk(1'b1,3'd4,16'h00FF, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd4,3'd2, 16'h00FF,16'h1234,1'b0,1'b0,8'h10);
        tbl[9]  = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd4,3'd4, 16'h00FF,16'h00FF,1'b0,1'b0,8'h00);
        tbl[10] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd6, 3'd6,3'd1, 16'h0000,16'h0000,1'b0,1'b0,8'h00);
        tbl[11] = mk(1'b0,3'd0,16'h0000, 1'b1,3'd6,16'h0A0A, 1'b1,3'd6, 3'd6,3'd6, 16'h0A0A,16'h0A0A,1'b1,1'b1,8'h40);
        tbl[12] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd6,3'd5, 16'h0A0A,16'hBEEF,1'b1,1'b0,8'h40);
        tbl[13] = mk(1'b1,3'd6,16'h5555, 1'b1,3'd1,16'h7777, 1'b0,3'd0, 3'd6,3'd1, 16'h5555,16'h7777,1'b0,1'b0,8'h40);
        tbl[14] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd6,3'd1, 16'h5555,16'h7777,1'b0,1'b0,8'h00);
        tbl[15] = mk(1'b1,3'd5,16'hAAAA, 1'b0,3'd0,16'h0000, 1'b1,3'd7, 3'd5,3'd7, 16'hAAAA,16'h0000,1'b0,1'b0,8'h00);
        tbl[16] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd5,3'd7, 16'hAAAA,16'h0000,1'b0,1'b1,8'h80);
        tbl[17] = mk(1'b1,3'd0,16'h0F0F, 1'b0,3'd0,16'h0000, 1'b1,3'd7, 3'd0,3'd7, 16'h0F0F,16'h0000,1'b0,1'b1,8'h80);
        tbl[18] = mk(1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd0,3'd7, 16'h0F0F,16'h0000,1'b0,1'b1,8'h80);

        // Power-on reset
        rst_n = 1'b0;
        idle();
        #3;
        chk("por rd1", rd1, 16'h0000);
        chk("por busy_vec", 16'(busy_vec), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven cycles against the bypassing build
        for (int i = 0; i < NROWS; i++) begin
            @(negedge clk);
            we_a = tbl[i].p_we_a; wa_a = tbl[i].p_wa_a; wd_a = tbl[i].p_wd_a;
            we_b = tbl[i].p_we_b; wa_b = tbl[i].p_wa_b; wd_b = tbl[i].p_wd_b;
            iss_v = tbl[i].p_iss; iss_dr = tbl[i].p_dr;
            ra1 = tbl[i].p_ra1; ra2 = tbl[i].p_ra2;
            exp_q.push_back(tbl[i].e);
            #2;
            e = exp_q.pop_front();
            chk($sformatf("row%0d rd1", i), rd1, e.e_rd1);
            chk($sformatf("row%0d rd2", i), rd2, e.e_rd2);
            chk($sformatf("row%0d rd1_busy", i), 16'(rd1_busy), 16'(e.e_b1));
            chk($sformatf("row%0d rd2_busy", i), 16'(rd2_busy), 16'(e.e_b2));
            chk($sformatf("row%0d busy_vec", i), 16'(busy_vec), 16'(e.e_bv));
        end

        // Mid-cycle reset with a write in flight: outputs clear at once, write is lost
        @(negedge clk);
        idle();
        we_a = 1'b1; wa_a = 3'd2; wd_a = 16'h9999; iss_v = 1'b1; iss_dr = 3'd3;
        ra1 = 3'd2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst rd1 bypass masked", rd1, 16'h0000);
        chk("rst busy_vec", 16'(busy_vec), 16'h0000);
        we_a = 1'b0; iss_v = 1'b0;
        for (int r = 0; r < 8; r++) begin
            ra1 = 3'(r);
            ra2 = 3'(7 - r);
            #0.25;
            chk($sformatf("rst r%0d rd1", r), rd1, 16'h0000);
            chk($sformatf("rst r%0d rd2", 7 - r), rd2, 16'h0000);
        end
        we_a = 1'b1; wa_a = 3'd2; wd_a = 16'h9999;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        ra1 = 3'd2; ra2 = 3'd5;
        #2;
        chk("post-rst lost write r2", rd1, 16'h0000);
        chk("post-rst r5 cleared", rd2, 16'h0000);
        chk("post-rst busy_vec", 16'(busy_vec), 16'h0000);

        // Collision: bypassing vs non-bypassing builds
        @(negedge clk);
        idle();
        we_a = 1'b1; wa_a = 3'd3; wd_a = 16'h1111;
        we_b = 1'b1; wa_b = 3'd3; wd_b = 16'h2222;
        ra1 = 3'd3;
        #2;
        chk("coll bypass rd1", rd1, 16'h2222);
        chk("coll nobypass rd1", nb_rd1, 16'h0000);
        @(negedge clk);
        idle();
        ra1 = 3'd3;
        #2;
        chk("coll after rd1", rd1, 16'h2222);
        chk("coll after nobypass rd1", nb_rd1, 16'h2222);

        // Hardwired r0: write and issue to r0 are ignored
        @(negedge clk);
        idle();
        we_a = 1'b1; wa_a = 3'd0; wd_a = 16'hFFFF;
        iss_v = 1'b1; iss_dr = 3'd0;
        ra1 = 3'd0;
        #2;
        chk("z0 write-cycle rd1", z_rd1, 16'h0000);
        chk("z0 write-cycle busy_vec", 16'(z_bv), 16'h0000);
        chk("r0 normal bypass rd1", rd1, 16'hFFFF);
        chk("r0 nobypass rd1", nb_rd1, 16'h0000);
        @(negedge clk);
        idle();
        ra1 = 3'd0;
        #2;
        chk("z0 after rd1", z_rd1, 16'h0000);
        chk("z0 after busy_vec", 16'(z_bv), 16'h0000);
        chk("z0 after rd1_busy", 16'(z_b1), 16'h0000);
        chk("r0 normal busy_vec", 16'(busy_vec), 16'h0001);
        chk("r0 normal rd1_busy", 16'(rd1_busy), 16'h0001);
        chk("r0 nobypass rd1", nb_rd1, 16'hFFFF);

        // Retiring write: bypass build hides busy, non-bypass build does not
        @(negedge clk);
        idle();
        we_a = 1'b1; wa_a = 3'd0; wd_a = 16'h0001;
        ra1 = 3'd0;
        #2;
        chk("retire bypass rd1_busy", 16'(rd1_busy), 16'h0000);
        chk("retire nobypass rd1_busy", 16'(nb_b1), 16'h0001);
        chk("retire nobypass rd1", nb_rd1, 16'hFFFF);
        @(negedge clk);
        idle();
        #2;
        chk("retired busy_vec", 16'(busy_vec), 16'h0000);
        chk("retired nobypass busy_vec", 16'(nb_bv), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_regfile_sb.md
Name: lc3_regfile_sb

Overview:
- Parametrised register file for the pipelined CPU datapath.
- Two combinational read ports and two write ports: port A for the ALU/writeback path, port B for the load/late path.
- Optional write-to-read bypass.
- Per-register scoreboard: pending bits are set at issue and cleared at writeback. Decode uses them to stall on RAW hazards.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = a read of a register being written this cycle returns the write data; 0 = returns the stored value
- ZERO_R0, 0, 1 = register 0 is hardwired to zero; writes and issues to it are ignored

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ra1  in  ADDR_W  read port 1 address
- ra2  in  ADDR_W  read port 2 address
- rd1  out  DATA_W  read port 1 data (combinational)
- rd2  out  DATA_W  read port 2 data (combinational)
- rd1_busy  out  1  scoreboard pending bit of ra1 (after bypass rule)
- rd2_busy  out  1  scoreboard pending bit of ra2 (after bypass rule)
- we_a  in  1  write enable, port A
- wa_a  in  ADDR_W  write address, port A
- wd_a  in  DATA_W  write data, port A
- we_b  in  1  write enable, port B
- wa_b  in  ADDR_W  write address, port B
- wd_b  in  DATA_W  write data, port B
- iss_v  in  1  issue valid: mark iss_dr pending
- iss_dr  in  ADDR_W  destination register of the issuing instruction
- busy_vec  out  2**ADDR_W  full pending-bit vector, for debug/stall logic

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low clears every register to 0 and every pending bit to 0, immediately, without waiting for a clock edge.
  - Outputs under reset: rd1 = rd2 = 0, rd1_busy = rd2_busy = 0, busy_vec = 0.
  - Reset asserted mid-write: the write is lost.
  - Deassertion takes effect at the next rising edge.
- Writes:
  - Registers update at the rising edge of clk.
  - Write latency is 1 cycle: data is visible through the array on the cycle after the edge.
  - we_a and we_b to different addresses: both are written in the same cycle.
  - we_a and we_b to the same address: port B wins, and port A's data is discarded.
- Reads:
  - rd1 = mem[ra1] and rd2 = mem[ra2] are purely combinational.
  - Both ports may address the same register.
- Bypass (BYPASS=1):
  - If we_b && wa_b == raN, then rdN = wd_b.
  - Else if we_a && wa_a == raN, then rdN = wd_a.
  - Else rdN = mem[raN].
  - Priority is the same as the write-collision rule.
  - With BYPASS=0 the stored value is always returned; new data appears the cycle after the edge.
- Scoreboard:
  - pend[r] is set at the edge when iss_v && iss_dr == r.
  - pend[r] is cleared at the edge when (we_a && wa_a == r) || (we_b && wa_b == r).
  - Issue and write to the same r in the same cycle: the set wins. A new producer issued while the old one retires leaves pend[r] = 1.
  - Writing a register that is not pending is legal; pend stays 0.
  - Issuing to an already-pending register is legal; pend stays 1. There is no counting, since in-order issue is guaranteed by the pipeline.
  - rdN_busy = pend[raN]. With BYPASS=1 it is forced to 0 when a write to raN is present this cycle and no issue to raN is present this cycle.
- ZERO_R0=1:
  - mem[0] and pend[0] are constant 0.
  - rd of address 0 returns 0 even when bypass would match.
- No other state; there are no output registers.

Test Plan:
- Reset then read: assert rst_n=0 mid-cycle, then release. All 8 registers read 0x0000 and busy_vec = 8'h00 without waiting for an edge.
- Dual write, read back: we_a r2=0x1234 and we_b r5=0xBEEF in the same cycle. Next cycle ra1=2 gives 0x1234 and ra2=5 gives 0xBEEF.
- Write collision:
  - we_a r3=0x1111 and we_b r3=0x2222 in one cycle; the following cycle r3 reads 0x2222.
  - Same cycle with BYPASS=1: ra1=3 gives 0x2222.
  - Same cycle with BYPASS=0: ra1=3 gives the old value 0x0000.
- Scoreboard:
  - Cycle 0, iss_v r4: busy_vec[4]=1 from cycle 1. In cycle 1, ra1=4 gives rd1_busy=1.
  - Cycle 3, we_a r4=0x00FF: during cycle 3 rd1_busy=0 and rd1=0x00FF (bypass). From cycle 4, busy_vec[4]=0.
- Issue/write race: r6 pending; in the same cycle iss_v r6 and we_b r6=0x0A0A. After the edge busy_vec[6]=1 and r6 holds 0x0A0A.
- ZERO_R0=1 build: we_a r0=0xFFFF and iss_v r0. r0 reads 0x0000, including in the write cycle, and busy_vec[0]=0 throughout.
